light_sequencer: RTL

- Timed phase sequencer that sits directly upstream of the traffic-light control unit.
- Drives the unit's 2-bit request code (00 none, 01 Red, 10 Green, 11 Yellow).
- Reads back the unit's one-hot control word (100 Red, 010 Green, 001 Yellow) to confirm each transition.
- Times phase durations, shortens Green on a pedestrian request, and flags any disagreement with the downstream unit.

---
 rtl/light_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/light_sequencer.sv
// Timed phase sequencer feeding the traffic-light control unit.
// Confirms each requested transition against the unit's one-hot feedback.
module light_sequencer #(
  parameter int CNT_W         = 16,
  parameter int RED_TICKS     = 8,
  parameter int GREEN_TICKS   = 10,
  parameter int YELLOW_TICKS  = 3,
  parameter int PED_MIN_GREEN = 4,
  parameter int REQ_TIMEOUT   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             ped_req,
  input  logic [2:0]       cw_traffic_lights,
  output logic [1:0]       sw_traffic_lights,
  output logic             ped_ack,
  output logic [CNT_W-1:0] phase_count,
  output logic             mismatch_err
);

  localparam int WD_W = $clog2(REQ_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] RED_LD =
    CNT_W'(RED_TICKS - 1);
  localparam logic [CNT_W-1:0] GREEN_LD =
    CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD =
    CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] CUT_MAX =
    CNT_W'(GREEN_TICKS - 1 - PED_MIN_GREEN);
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'(REQ_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TIME,
    S_REQ
  } state_e;

  typedef enum logic [1:0] {
    PH_RED,
    PH_GREEN,
    PH_YELLOW
  } phase_e;

  function automatic logic [2:0] onehot(input phase_e p);
    unique case (p)
      PH_GREEN:  onehot = 3'b010;
      PH_YELLOW: onehot = 3'b001;
      default:   onehot = 3'b100;
    endcase
  endfunction

  function automatic logic [1:0] code(input phase_e p);
    unique case (p)
      PH_GREEN:  code = 2'b10;
      PH_YELLOW: code = 2'b11;
      default:   code = 2'b01;
    endcase
  endfunction

  function automatic phase_e succ(input phase_e p);
    unique case (p)
      PH_RED:   succ = PH_GREEN;
      PH_GREEN: succ = PH_YELLOW;
      default:  succ = PH_RED;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] ld(input phase_e p);
    unique case (p)
      PH_GREEN:  ld = GREEN_LD;
      PH_YELLOW: ld = YELLOW_LD;
      default:   ld = RED_LD;
    endcase
  endfunction

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  phase_e           target_q, target_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [1:0]       sw_q, sw_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             pend_q, pend_d;
  logic             serve;
  logic             cut;

  // Green may be cut short once it has run its minimum time.
  assign cut = (phase_q == PH_GREEN) && pend_q &&
               (count_q <= CUT_MAX);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    target_d = target_q;
    count_d  = count_q;
    wd_d     = wd_q;
    err_d    = err_q;
    sw_d     = 2'b00;
    serve    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable && !err_q &&
            cw_traffic_lights == onehot(PH_RED)) begin
          phase_d = PH_RED;
          count_d = RED_LD;
          state_d = S_TIME;
          serve   = pend_q;
        end
      end
      S_TIME: begin
        if (cw_traffic_lights != onehot(phase_q)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (enable) begin
          if (count_q == '0 || cut) begin
            target_d = succ(phase_q);
            wd_d     = '0;
            sw_d     = code(succ(phase_q));
            state_d  = S_REQ;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
      end
      S_REQ: begin
        if (cw_traffic_lights == onehot(target_q)) begin
          phase_d = target_q;
          count_d = ld(target_q);
          state_d = S_TIME;
          serve   = (target_q == PH_RED) && pend_q;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
          sw_d = code(target_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
    ack_d  = serve;
    // A new request in the serving cycle keeps the flag set.
    pend_d = ped_req | (pend_q & ~serve);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      phase_q  <= PH_RED;
      target_q <= PH_RED;
      count_q  <= '0;
      wd_q     <= '0;
      sw_q     <= 2'b00;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      target_q <= target_d;
      count_q  <= count_d;
      wd_q     <= wd_d;
      sw_q     <= sw_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      pend_q   <= pend_d;
    end
  end

  assign sw_traffic_lights = sw_q;
  assign ped_ack           = ack_q;
  assign phase_count       = count_q;
  assign mismatch_err      = err_q;

endmodule
